// File: rtl/pulse_sync_multi.sv
// Multi-channel fast-to-slow pulse synchroniser. Each channel counts pending events and
// delivers them one at a time to the sclk domain over a four-phase req/ack handshake.
module pulse_sync_multi #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic           fclk,
  input  logic           reset,
  input  logic           sclk,
  input  logic [NCH-1:0] f_in,
  input  logic [NCH-1:0] f_ovf_clr,
  output logic [NCH-1:0] f_busy,
  output logic [NCH-1:0] f_overflow,
  output logic [NCH-1:0] s_out
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitLow} state_e;

  localparam logic [CNT_W-1:0] PMax = '1;

  // Reset for the sclk domain: the fclk-domain reset level re-timed onto sclk.
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   reset_s;

  always_ff @(posedge sclk) begin
    rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], reset};
  end

  assign reset_s = rst_sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e                 state_q;
    logic                   req_q;
    logic [CNT_W-1:0]       pc_q;
    logic [CNT_W-1:0]       pc_d;
    logic                   ovf_q;
    logic                   busy_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_f;
    logic                   launch;
    logic                   drop;
    logic                   busy_d;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   ack_s;
    logic                   ack_prev_q;
    logic                   s_out_q;

    assign ack_f = ack_sync_q[SYNC_STAGES-1];

    // A launch takes the live strobe if there is one, so the count only moves when it is idle.
    always_comb begin
      launch = (state_q == StIdle) && (f_in[g] || (pc_q != '0));
      drop   = f_in[g] && !launch && (pc_q == PMax);
      pc_d   = pc_q;
      if (launch && !f_in[g]) begin
        pc_d = pc_q - 1'b1;
      end else if (f_in[g] && !launch && (pc_q != PMax)) begin
        pc_d = pc_q + 1'b1;
      end
      unique case (state_q)
        StIdle:    busy_d = launch;
        StReq:     busy_d = 1'b1;
        StWaitLow: busy_d = ack_f;
        default:   busy_d = 1'b0;
      endcase
      busy_d = busy_d || (pc_d != '0);
    end

    always_ff @(posedge fclk) begin
      if (reset) begin
        state_q    <= StIdle;
        req_q      <= 1'b0;
        pc_q       <= '0;
        ovf_q      <= 1'b0;
        busy_q     <= 1'b0;
        ack_sync_q <= '0;
      end else begin
        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_s};
        pc_q       <= pc_d;
        busy_q     <= busy_d;
        if (drop) begin
          ovf_q <= 1'b1;
        end else if (f_ovf_clr[g]) begin
          ovf_q <= 1'b0;
        end
        unique case (state_q)
          StIdle: begin
            if (launch) begin
              state_q <= StReq;
              req_q   <= 1'b1;
            end
          end
          StReq: begin
            if (ack_f) begin
              state_q <= StWaitLow;
              req_q   <= 1'b0;
            end
          end
          StWaitLow: begin
            if (!ack_f) begin
              state_q <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
            req_q   <= 1'b0;
          end
        endcase
      end
    end

    // Only registered req crosses into sclk; only registered ack_s crosses back.
    always_ff @(posedge sclk) begin
      if (reset_s) begin
        req_sync_q <= '0;
        ack_prev_q <= 1'b0;
        s_out_q    <= 1'b0;
      end else begin
        req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
        ack_prev_q <= ack_s;
        s_out_q    <= ack_s && !ack_prev_q;
      end
    end

    assign ack_s         = req_sync_q[SYNC_STAGES-1];
    assign f_busy[g]     = busy_q;
    assign f_overflow[g] = ovf_q;
    assign s_out[g]      = s_out_q;
  end

endmodule

// File: tb/tb_pulse_sync_multi.sv
// Directed and randomised checks of pulse_sync_multi: per-channel delivery counts,
// overflow behaviour, reset mid-transfer and a scoreboard over random clock ratios.
`timescale 1ns / 1ps
module tb_pulse_sync_multi;

  localparam int NCH = 4;

  logic           fclk = 1'b0;
  logic           sclk = 1'b0;
  logic           reset;
  logic [NCH-1:0] f_in;
  logic [NCH-1:0] f_ovf_clr;
  logic [NCH-1:0] f_busy;
  logic [NCH-1:0] f_overflow;
  logic [NCH-1:0] s_out;

  real sclk_half = 18.5;

  always #5 fclk = ~fclk;
  always #(sclk_half) sclk = ~sclk;

  pulse_sync_multi #(
    .NCH        (NCH),
    .SYNC_STAGES(2),
    .CNT_W      (3)
  ) dut (
    .fclk      (fclk),
    .reset     (reset),
    .sclk      (sclk),
    .f_in      (f_in),
    .f_ovf_clr (f_ovf_clr),
    .f_busy    (f_busy),
    .f_overflow(f_overflow),
    .s_out     (s_out)
  );

  int           checks = 0;
  int           errors = 0;
  int           s_cnt   [NCH];
  int           in_tot  [NCH];
  int           width_err = 0;
  logic [NCH-1:0] s_prev = '0;

  // Pulse counter and width monitor, sampled mid sclk period.
  always @(negedge sclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (s_out[i] === 1'b1) begin
        s_cnt[i]++;
        if (s_prev[i] === 1'b1) width_err++;
      end
    end
    s_prev = s_out;
  end

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NCH-1:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      f_in = v;
      for (int i = 0; i < NCH; i++) if (v[i]) in_tot[i]++;
      @(negedge fclk);
    end
    f_in = '0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (f_busy !== '0 && n < 5000) begin
      @(negedge fclk);
      n++;
    end
    check({name, "_idle"}, int'(f_busy !== '0), 0);
    repeat (60) @(negedge fclk);
  endtask

  typedef struct {
    logic [NCH-1:0] f_in;
    int             hold;
    int             exp_cnt [NCH];
    logic [NCH-1:0] exp_ovf;
  } vec_t;

  vec_t vecs [6];
  int   base [NCH];
  int   wbase;

  initial begin
    vecs[0] = '{4'b0001, 1,  '{1, 0, 0, 0}, 4'b0000};
    vecs[1] = '{4'b0010, 5,  '{0, 5, 0, 0}, 4'b0000};
    vecs[2] = '{4'b1111, 1,  '{1, 1, 1, 1}, 4'b0000};
    vecs[3] = '{4'b1010, 2,  '{0, 2, 0, 2}, 4'b0000};
    vecs[4] = '{4'b1000, 3,  '{0, 0, 0, 3}, 4'b0000};
    vecs[5] = '{4'b0100, 12, '{0, 0, 8, 0}, 4'b0100};

    reset     = 1'b1;
    f_in      = '0;
    f_ovf_clr = '0;
    repeat (30) @(negedge fclk);
    check("rst_busy", int'(f_busy), 0);
    check("rst_ovf", int'(f_overflow), 0);
    check("rst_sout", int'(s_out), 0);
    reset = 1'b0;
    repeat (20) @(negedge fclk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < NCH; i++) base[i] = s_cnt[i];
      wbase = width_err;
      drive(vecs[v].f_in, vecs[v].hold);
      wait_idle($sformatf("vec%0d", v));
      for (int i = 0; i < NCH; i++)
        check($sformatf("vec%0d_cnt%0d", v, i), s_cnt[i] - base[i], vecs[v].exp_cnt[i]);
      check($sformatf("vec%0d_ovf", v), int'(f_overflow), int'(vecs[v].exp_ovf));
      check($sformatf("vec%0d_width", v), width_err - wbase, 0);
    end

    // Overflow stays set, then clears on request.
    repeat (50) @(negedge fclk);
    check("ovf_sticky", int'(f_overflow[2]), 1);
    f_ovf_clr = 4'b0100;
    @(negedge fclk);
    f_ovf_clr = '0;
    check("ovf_clr", int'(f_overflow[2]), 0);

    // A drop in the same cycle as a clear leaves the flag set.
    base[2] = s_cnt[2];
    drive(4'b0100, 11);
    f_in      = 4'b0100;
    f_ovf_clr = 4'b0100;
    @(negedge fclk);
    f_in      = '0;
    f_ovf_clr = '0;
    check("ovf_set_wins", int'(f_overflow[2]), 1);
    wait_idle("setwins");
    check("setwins_cnt", s_cnt[2] - base[2], 8);
    check("setwins_sticky", int'(f_overflow[2]), 1);
    f_ovf_clr = 4'b0100;
    @(negedge fclk);
    f_ovf_clr = '0;
    check("setwins_clr", int'(f_overflow[2]), 0);

    // Reset while channel 3 has a request in flight and three events pending.
    drive(4'b1000, 4);
    check("pre_rst_busy3", int'(f_busy[3]), 1);
    reset = 1'b1;
    repeat (30) @(negedge fclk);
    reset = 1'b0;
    base[3] = s_cnt[3];
    check("post_rst_busy", int'(f_busy), 0);
    repeat (200) @(negedge fclk);
    check("post_rst_busy_late", int'(f_busy), 0);
    check("post_rst_cnt3", s_cnt[3] - base[3], 0);
    check("post_rst_ovf", int'(f_overflow), 0);

    // Random traffic at random clock ratios; overflow must explain every missing pulse.
    for (int r = 0; r < 4; r++) begin
      sclk_half = 7.5 + 0.5 * real'($urandom_range(0, 65));
      repeat (20) @(negedge fclk);
      for (int i = 0; i < NCH; i++) begin
        base[i]   = s_cnt[i];
        in_tot[i] = 0;
      end
      wbase = width_err;
      for (int k = 0; k < 300; k++) begin
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = ($urandom_range(0, 5) == 0);
        drive(v, 1);
      end
      wait_idle($sformatf("rnd%0d", r));
      for (int i = 0; i < NCH; i++) begin
        int dc;
        dc = s_cnt[i] - base[i];
        check($sformatf("rnd%0d_le%0d", r, i), int'(dc <= in_tot[i]), 1);
        if (f_overflow[i]) check($sformatf("rnd%0d_drop%0d", r, i), int'(dc < in_tot[i]), 1);
        else               check($sformatf("rnd%0d_eq%0d", r, i), dc, in_tot[i]);
      end
      check($sformatf("rnd%0d_width", r), width_err - wbase, 0);
      f_ovf_clr = '1;
      @(negedge fclk);
      f_ovf_clr = '0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sync_multi.md
PULSE_SYNC_MULTI -- requirements
Module: pulse_sync_multi

Interface
REQ-001 SHALL provide parameter NCH, default 4: number of independent fast-to-slow pulse channels, range 1..32.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2: flops per synchroniser chain, range 2..4.
REQ-003 SHALL provide parameter CNT_W, default 3: per-channel pending-count width; PMAX = 2^CNT_W-1.
REQ-004 fclk  input  1  fast clock; all f_* signals are synchronous to it.
REQ-005 reset  input  1  reset, synchronous, active-high; clock fclk.
REQ-006 sclk  input  1  slow clock, asynchronous to fclk.
REQ-007 f_in  input  NCH  per-channel event strobe; each fclk cycle high counts as one event.
REQ-008 f_ovf_clr  input  NCH  per-channel clear for f_overflow.
REQ-009 f_busy  output  NCH  channel has a transfer in flight or a pending count above zero.
REQ-010 f_overflow  output  NCH  sticky flag: at least one event on the channel was dropped.
REQ-011 s_out  output  NCH  registered single-sclk-cycle pulse per delivered event.

Function (per channel, channels fully independent)
REQ-012 SHALL keep a CNT_W-bit pending counter PC and a four-phase handshake FSM, IDLE -> REQ -> WAIT_LOW -> IDLE.
REQ-013 In IDLE with f_in=1 or PC>0, SHALL enter REQ and drive req level 1 on the next fclk edge.
REQ-014 A launch SHALL consume the current f_in if one is present (PC unchanged); otherwise it SHALL consume one count (PC-1).
REQ-015 SHALL hold req at 1 in REQ until the fclk-synchronised ack reads 1, then drop req and enter WAIT_LOW.
REQ-016 In WAIT_LOW, SHALL return to IDLE when synchronised ack reads 0; no new launch until then.
REQ-017 Outside a consuming launch, f_in=1 SHALL increment PC, saturating at PMAX.
REQ-018 f_in=1 with PC=PMAX and no simultaneous decrement SHALL drop the event and set f_overflow on the next edge.
REQ-019 If f_in=1 coincides with a consume of PC, PC SHALL stay unchanged and no overflow SHALL occur.
REQ-020 f_overflow SHALL clear on f_ovf_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-021 f_busy SHALL be registered and equal (state!=IDLE) or (PC>0).
REQ-022 The sclk side SHALL pass req through SYNC_STAGES flops; the last stage is ack_s.
REQ-023 On ack_s 0->1, the sclk side SHALL assert s_out for exactly one sclk cycle, registered.
REQ-024 ack_s SHALL be returned to fclk through SYNC_STAGES flops to form the synchronised ack.
REQ-025 Each delivered event SHALL produce exactly one s_out pulse; no event SHALL be duplicated.
REQ-026 Sustained throughput SHALL be one event per handshake round trip; excess events accumulate in PC.
REQ-027 Latency from req rise to s_out SHALL be SYNC_STAGES+1 sclk edges (+1 for sampling uncertainty).
REQ-028 No combinational path SHALL cross between the fclk and sclk domains.

Reset
REQ-029 reset SHALL clear PC, f_overflow and f_busy to 0 and return the FSM to IDLE with req=0.
REQ-030 The sclk-domain flops SHALL be reset by reset_s: reset passed through SYNC_STAGES sclk flops, active-high, synchronous to sclk.
REQ-031 reset SHALL be held at least SYNC_STAGES+2 sclk periods; then s_out=0 and ack_s=0.
REQ-032 Reset mid-transfer SHALL discard pending and in-flight events; no s_out pulse SHALL appear for them after reset release.

Verification (NCH=4, SYNC_STAGES=2, CNT_W=3, fclk 100 MHz, sclk 27 MHz)
REQ-033 Single 1-cycle f_in[0] pulse from idle -> exactly one s_out[0] pulse within 4 sclk edges; f_busy[0] returns to 0; f_overflow=0.
REQ-034 f_in[1] held high for 5 fclk cycles -> exactly 5 s_out[1] pulses, each 1 sclk wide; PC peaks at 4; f_overflow[1]=0.
REQ-035 f_in[2] high for 12 cycles while busy -> PC saturates at 7, f_overflow[2]=1 and stays 1; s_out count = 1 + 7 (+1 per launch during burst); f_ovf_clr[2] then clears the flag.
REQ-036 f_in on all 4 channels in the same cycle -> each channel delivers one s_out pulse independently; pulses in any order, no cross-channel effect.
REQ-037 reset asserted while channel 3 is in REQ with PC=3 -> after release, f_busy[3]=0, PC=0, no further s_out[3] pulses.
REQ-038 Random f_in, random clock ratios 1.5-8 -> scoreboard: s_out total = f_in total - dropped events; dropped events > 0 only if f_overflow set.
